// File: rtl/settings_bus_pkg.sv
// Shared types and defaults for the settings bus arbiter.
// Imported by the arbiter top and its testbench.
package settings_bus_pkg;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 32;
  localparam int GAP_MAX = 15;

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1 with wrap.
// Emits a one-hot grant, its index and whether any request was seen.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing one single-strobe settings bus among requesters,
// with locked multi-write sequences and a programmable inter-strobe gap.
module settings_bus_arbiter
  import settings_bus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int AWIDTH     = AW_DEF,
  parameter int DWIDTH     = DW_DEF,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  input  logic [NUM_REQ*AWIDTH-1:0]     in_addr,
  input  logic [NUM_REQ*DWIDTH-1:0]     in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          set_stb,
  output logic [AWIDTH-1:0]             set_addr,
  output logic [DWIDTH-1:0]             set_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked
);

  localparam int IW = idx_w(NUM_REQ);

  state_t               state;
  logic [3:0]           gap_cnt;
  logic [IW-1:0]        last_idx;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [IW-1:0]        sel;
  logic                 accept;
  logic [AWIDTH-1:0]    sel_addr;
  logic [DWIDTH-1:0]    sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req  (in_valid),
    .last (last_idx),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Reset gates the handshake so nothing is accepted in a reset cycle.
  always_comb begin
    in_ready = '0;
    if (!reset && gap_cnt == 4'd0) begin
      unique case (state)
        ARB:  in_ready = arb_any ? arb_gnt : '0;
        LOCK: in_ready[grant_id] = in_valid[grant_id];
        default: in_ready = '0;
      endcase
    end
  end

  assign sel      = (state == LOCK) ? grant_id : arb_idx;
  assign accept   = |(in_ready & in_valid);
  assign sel_addr = in_addr[int'(sel)*AWIDTH +: AWIDTH];
  assign sel_data = in_data[int'(sel)*DWIDTH +: DWIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      gap_cnt  <= 4'd0;
      last_idx <= IW'(NUM_REQ - 1);
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
    end else if (accept) begin
      set_stb  <= 1'b1;
      set_addr <= sel_addr;
      set_data <= sel_data;
      grant_id <= sel;
      last_idx <= sel;
      gap_cnt  <= 4'(GAP_CYCLES);
      state    <= in_last[sel] ? ARB : LOCK;
      locked   <= !in_last[sel];
    end else begin
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: doc/settings_bus_arbiter.md
Name: settings_bus_arbiter

Overview:
Shares one settings bus (stb/addr/data, single-cycle strobe write) among NUM_REQ requesters.
- Each requester offers a write with a valid/ready handshake.
- The block arbitrates round-robin, supports locked multi-write sequences, and enforces a programmable minimum gap between strobes.
- It sits between control sources (host command decoder, local sequencers, BIST) and the settings-register fabric of a radio/DSP core.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
AWIDTH, 8, settings address width
DWIDTH, 32, settings data width
GAP_CYCLES, 0, minimum idle cycles forced between consecutive set_stb pulses (0..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  NUM_REQ  per-requester write request
in_last  in  NUM_REQ  1 = this write ends the requester's sequence; 0 = keep grant locked
in_addr  in  NUM_REQ*AWIDTH  packed addresses; requester i at [i*AWIDTH +: AWIDTH]
in_data  in  NUM_REQ*DWIDTH  packed data; requester i at [i*DWIDTH +: DWIDTH]
in_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle
set_stb  out  1  settings write strobe, one cycle per write
set_addr  out  AWIDTH  settings address
set_data  out  DWIDTH  settings data
grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current/last strobe
locked  out  1  high while a requester holds the grant between beats of a sequence

Behaviour:
- Reset (sync, active-high) forces:
  - set_stb=0, set_addr=0, set_data=0, grant_id=0, locked=0, in_ready=0.
  - State ARB, gap counter 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-sequence drops the lock and any pending strobe. No strobe is issued in the cycle after reset.
- Handshake: a write is accepted when in_valid[i] && in_ready[i] in the same cycle. in_ready is combinational from state, counter and in_valid.
- in_ready is low whenever gap_cnt != 0.
- State ARB (gap_cnt==0):
  - Grant = first requester with in_valid set, searching from last+1 upward with wrap-around.
  - in_ready[grant]=1. If no in_valid, in_ready=0.
- State LOCK (gap_cnt==0):
  - in_ready[owner]=in_valid[owner]; all other in_ready=0, regardless of their in_valid.
  - The owner may deassert in_valid indefinitely; the lock holds, with no timeout.
- On accept:
  - Register addr/data; update grant_id and last to the granted index.
  - Next cycle: set_stb=1 with that addr/data. Latency is exactly 1 cycle.
  - gap_cnt loads GAP_CYCLES.
- Transitions:
  - Accept with in_last=0: go to LOCK, locked=1.
  - Accept with in_last=1: go to ARB, locked=0.
  - locked changes in the cycle after the accept.
- Gap counter: decrements each cycle while nonzero. No accept while nonzero.
- Throughput:
  - GAP_CYCLES=0: back-to-back strobes every cycle.
  - Otherwise: one strobe per GAP_CYCLES+1 cycles.
- set_addr/set_data are 0 in every cycle set_stb=0.
- grant_id holds its last value between strobes.
- Simultaneous requests: exactly one is granted per accept slot. Pending requesters wait with in_valid held. Requester-side inputs must stay stable while in_valid=1 and unaccepted.
- Lock owner deasserting in_valid with in_last never sent: the bus remains locked. This is a documented requester obligation, not handled by the block.
- Starvation bound: in ARB, any requester holding in_valid is granted within NUM_REQ accepts, excluding locked sequences.

Decomposition:
- Package settings_bus_pkg:
  - Default AWIDTH/DWIDTH constants.
  - State enum {ARB, LOCK}.
  - Function clog2-based index width.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, grant index, any.
  - Reusable elsewhere.
- Top module holds the FSM, gap counter and output registers.

Test Plan:
- Single write, NUM_REQ=4, GAP=0: req1 addr 0x10 data 0xDEADBEEF, in_last=1 -> in_ready[1] same cycle; next cycle set_stb=1, set_addr=0x10, set_data=0xDEADBEEF, grant_id=1; following cycle set_stb=0, addr/data=0.
- Round-robin: all four in_valid continuously, in_last=1, GAP=0 -> strobes every cycle, grant order 0,1,2,3,0.
- Lock: req2 sends 3 writes (in_last=0,0,1) to 0x20/0x21/0x22 while req0/req3 valid -> three consecutive strobes from req2, locked=1 between them; next grant is req3, then req0.
- Gap: GAP_CYCLES=3, req0 and req1 both valid -> strobes 4 cycles apart; in_ready all 0 during the 3 gap cycles.
- Stall in lock: req1 sends in_last=0, then drops in_valid 5 cycles while req0 valid -> no strobe and in_ready[0]=0 for those 5 cycles; req1 resumes with in_last=1 -> accepted, then req0 granted.
- Reset mid-lock: assert reset during LOCK with a write accepted in the same cycle -> next cycle set_stb=0, locked=0; first post-reset grant goes to req0 when all are valid.
